// File: rtl/efuse_ctrl.sv
// -----------------------------------------------------------------------------
// efuse_ctrl
//
// Sequencing controller placed in front of a 32-bit eFuse macro driver. It runs
// in the 25 MHz oscillator domain and talks to the driver over two start/ack
// handshakes (read and program).
//
// Behaviour summary:
//   * After reset it loads the fuse word into a shadow register (boot load,
//     no host_done).
//   * In IDLE it serves host reload and host program requests. Read has
//     priority when both requests arrive together.
//   * Programming is refused while the shadow lock bit is set.
//   * Only bits not yet blown are sent to the driver.
//   * Every program is followed, after a fixed settle time, by an automatic
//     verify read.
//   * Every wait on the driver is bounded by a timeout.
//
// Ports:
//   clk, rst                       25 MHz clock, synchronous active-high reset
//   host_rd_req / host_pg_req      one-cycle request pulses, honoured in IDLE only
//   host_pg_data                   bits to blow, sampled with host_pg_req
//   host_busy                      controller not in IDLE
//   host_done / host_err           one-cycle completion pulse and result code
//                                  (0 ok, 1 locked, 2 verify fail, 3 timeout)
//   shadow / shadow_valid / locked last fuse word read, its validity, lock status
//   read_start / read_ack          driver read handshake
//   dout / dout_valid              driver read data and its strobe
//   prog_start / prog_ack          driver program handshake
//   efuse_din                      program data, stable while programming
// -----------------------------------------------------------------------------
module efuse_ctrl #(
    parameter int LOCK_BIT  = 31,
    parameter int PROG_WAIT = 8400,
    parameter int TIMEOUT   = 16383
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_rd_req,
    input  logic        host_pg_req,
    input  logic [31:0] host_pg_data,
    output logic        host_busy,
    output logic        host_done,
    output logic [1:0]  host_err,
    output logic [31:0] shadow,
    output logic        shadow_valid,
    output logic        locked,
    output logic        read_start,
    input  logic        read_ack,
    input  logic [31:0] dout,
    input  logic        dout_valid,
    output logic        prog_start,
    input  logic        prog_ack,
    output logic [31:0] efuse_din
);

    typedef enum logic [2:0] {
        BOOT_RD = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        IDLE    = 3'd3,
        PG_REQ  = 3'd4,
        PG_HOLD = 3'd5,
        VF_REQ  = 3'd6,
        VF_WAIT = 3'd7
    } state_t;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_LOCKED = 2'd1;
    localparam logic [1:0] ERR_VERIFY = 2'd2;
    localparam logic [1:0] ERR_TMO    = 2'd3;

    // The counter is cleared on state entry, so the last value it reaches
    // before expiry is one less than the configured cycle count.
    localparam logic [13:0] TMO_LAST  = 14'(TIMEOUT - 1);
    localparam logic [13:0] HOLD_LAST = 14'(PROG_WAIT - 1);

    // A verify passes when every bit we asked to blow reads back as 1.
    // Other bits are not judged.
    function automatic logic verify_ok(input logic [31:0] rd, input logic [31:0] wb);
        return (rd & wb) == wb;
    endfunction

    state_t      state;
    logic [13:0] cnt;
    logic        is_boot;   // the current read sequence is the post-reset load
    logic [31:0] wbits;

    // Bits that still need blowing for the pending host program request.
    always_comb begin
        wbits = host_pg_data & ~shadow;
    end

    // Controller state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT_RD;
            cnt          <= 14'd0;
            is_boot      <= 1'b1;
            host_busy    <= 1'b0;
            host_done    <= 1'b0;
            host_err     <= ERR_OK;
            shadow       <= 32'd0;
            shadow_valid <= 1'b0;
            locked       <= 1'b0;
            read_start   <= 1'b0;
            prog_start   <= 1'b0;
            efuse_din    <= 32'd0;
        end else begin
            // Defaults: done is a pulse, busy stays up unless a branch
            // lands in IDLE, and the counter runs in every non-IDLE state.
            host_done <= 1'b0;
            host_busy <= 1'b1;
            cnt       <= cnt + 14'd1;

            case (state)
                BOOT_RD, RD_REQ, VF_REQ: begin
                    if (read_start && read_ack) begin
                        read_start <= 1'b0;
                        state      <= (state == VF_REQ) ? VF_WAIT : RD_WAIT;
                        cnt        <= 14'd0;
                    end else if (cnt == TMO_LAST) begin
                        // Driver never acknowledged: abandon, shadow untouched.
                        read_start <= 1'b0;
                        state      <= IDLE;
                        host_busy  <= 1'b0;
                        efuse_din  <= 32'd0;
                        cnt        <= 14'd0;
                        is_boot    <= 1'b0;
                        if (!is_boot) begin
                            host_done <= 1'b1;
                            host_err  <= ERR_TMO;
                        end else begin
                            host_done <= 1'b0;
                        end
                    end else begin
                        // Covers the boot load, whose request rises one
                        // cycle after reset release.
                        read_start <= 1'b1;
                    end
                end

                RD_WAIT, VF_WAIT: begin
                    if (dout_valid) begin
                        shadow       <= dout;
                        shadow_valid <= 1'b1;
                        locked       <= dout[LOCK_BIT];
                        state        <= IDLE;
                        host_busy    <= 1'b0;
                        efuse_din    <= 32'd0;
                        cnt          <= 14'd0;
                        is_boot      <= 1'b0;
                        if (state == VF_WAIT) begin
                            host_done <= 1'b1;
                            host_err  <= verify_ok(dout, efuse_din) ? ERR_OK : ERR_VERIFY;
                        end else if (!is_boot) begin
                            host_done <= 1'b1;
                            host_err  <= ERR_OK;
                        end else begin
                            host_done <= 1'b0;
                        end
                    end else if (cnt == TMO_LAST) begin
                        state     <= IDLE;
                        host_busy <= 1'b0;
                        efuse_din <= 32'd0;
                        cnt       <= 14'd0;
                        is_boot   <= 1'b0;
                        if (!is_boot) begin
                            host_done <= 1'b1;
                            host_err  <= ERR_TMO;
                        end else begin
                            host_done <= 1'b0;
                        end
                    end else begin
                        state <= state;
                    end
                end

                IDLE: begin
                    host_busy <= 1'b0;
                    cnt       <= 14'd0;
                    if (host_rd_req) begin
                        // A simultaneous program request is dropped.
                        state      <= RD_REQ;
                        read_start <= 1'b1;
                        host_busy  <= 1'b1;
                    end else if (host_pg_req) begin
                        if (locked) begin
                            host_done <= 1'b1;
                            host_err  <= ERR_LOCKED;
                        end else if (wbits == 32'd0) begin
                            // Nothing left to blow: succeed without the driver.
                            host_done <= 1'b1;
                            host_err  <= ERR_OK;
                        end else begin
                            efuse_din  <= wbits;
                            prog_start <= 1'b1;
                            state      <= PG_REQ;
                            host_busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                PG_REQ: begin
                    if (prog_start && prog_ack) begin
                        prog_start <= 1'b0;
                        state      <= PG_HOLD;
                        cnt        <= 14'd0;
                    end else if (cnt == TMO_LAST) begin
                        prog_start <= 1'b0;
                        state      <= IDLE;
                        host_busy  <= 1'b0;
                        efuse_din  <= 32'd0;
                        cnt        <= 14'd0;
                        host_done  <= 1'b1;
                        host_err   <= ERR_TMO;
                    end else begin
                        prog_start <= 1'b1;
                    end
                end

                PG_HOLD: begin
                    // Give the driver time to finish blowing before read-back.
                    // efuse_din is kept as the verify mask.
                    if (cnt == HOLD_LAST) begin
                        state      <= VF_REQ;
                        read_start <= 1'b1;
                        cnt        <= 14'd0;
                    end else begin
                        state <= PG_HOLD;
                    end
                end

                default: begin
                    state      <= IDLE;
                    host_busy  <= 1'b0;
                    read_start <= 1'b0;
                    prog_start <= 1'b0;
                    efuse_din  <= 32'd0;
                    cnt        <= 14'd0;
                end
            endcase
        end
    end

endmodule
